// File: rtl/div_queue_if.sv
// Stream and divider-side signals of div_queue.
// master: the environment (upstream, downstream and divider);
// slave: the queue itself.
interface div_queue_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
);
  localparam int LVLW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAGW-1:0]  in_tag;
  logic [LVLW-1:0]  level;

  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_done;
  logic             div_dbz;
  logic             div_ovf;
  logic [WIDTH-1:0] div_val;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [TAGW-1:0]  out_tag;
  logic             out_dbz;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
           div_done, div_dbz, div_ovf, div_val,
    input  in_ready, level, div_start, div_a, div_b,
           out_valid, out_val, out_tag, out_dbz, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
           div_done, div_dbz, div_ovf, div_val,
    output in_ready, level, div_start, div_a, div_b,
           out_valid, out_val, out_tag, out_dbz, out_ovf
  );
endinterface

// File: rtl/div_queue.sv
// Operand FIFO and single-slot result collector wrapped around the
// fixed-point divider. One operation is in flight at a time, and a new one
// is only issued once the result slot is empty, so a done pulse always has
// somewhere to land.
//
// state  | meaning
// S_IDLE | waiting for a queued operand pair and an empty result slot
// S_WAIT | operation issued, waiting for the divider's done pulse
module div_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  div_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state;
  logic [TAGW-1:0]  tag_q;
  logic             div_start_q;
  logic [WIDTH-1:0] div_a_q;
  logic [WIDTH-1:0] div_b_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_val_q;
  logic [TAGW-1:0]  out_tag_q;
  logic             out_dbz_q;
  logic             out_ovf_q;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.in_valid && !full;
  assign pop   = (state == S_IDLE) && !empty && !out_valid_q;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign bus.in_ready  = !full;
  assign bus.level     = wr_ptr - rd_ptr;
  assign bus.div_start = div_start_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_val   = out_val_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_dbz   = out_dbz_q;
  assign bus.out_ovf   = out_ovf_q;

  // Operand storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
    end
  end

  // FIFO pointers, wrapping naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Issue/collect FSM with all divider-side and result-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tag_q       <= '0;
      div_start_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_tag_q   <= '0;
      out_dbz_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          div_start_q <= 1'b0;
          if (pop) begin
            div_a_q     <= head.a;
            div_b_q     <= head.b;
            tag_q       <= head.tag;
            div_start_q <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          div_start_q <= 1'b0;
          // Slot is known empty here because issue was gated on it.
          if (bus.div_done) begin
            out_val_q   <= (bus.div_dbz || bus.div_ovf) ? '0 : bus.div_val;
            out_dbz_q   <= bus.div_dbz;
            out_ovf_q   <= bus.div_ovf;
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_queue.sv
// Directed bench for div_queue. A behavioural Q4.4 divider with a fixed
// start-to-done latency of 4 cycles stands in for the real divider.
module tb_div_queue;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  logic clk = 1'b0;
  logic rst;
  logic stray_done;

  int n_pass  = 0;
  int n_total = 0;

  int cyc        = 0;
  int start_cnt  = 0;
  int last_start = 0;
  int start_gap  = 0;

  logic       mdl_busy;
  logic [2:0] mdl_cnt;
  logic       mdl_done;
  logic [7:0] ma;
  logic [7:0] mb;
  logic [9:0] mdl_res;

  div_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();

  div_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Q4.4 signed divide: {dbz, ovf, val}; val is deliberately non-zero garbage on errors.
  function automatic logic [9:0] div_model(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int q;
    logic [7:0] qv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {2'b10, 8'hFF};
    q  = (sa * 16) / sb;
    qv = q[7:0];
    if (q > 127 || q < -127) return {2'b01, qv};
    return {2'b00, qv};
  endfunction

  assign mdl_res     = div_model(ma, mb);
  assign bus.div_done = mdl_done | stray_done;
  assign bus.div_dbz  = mdl_res[9];
  assign bus.div_ovf  = mdl_res[8];
  assign bus.div_val  = mdl_res[7:0];

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_cnt  <= 3'd0;
    end else begin
      mdl_done <= 1'b0;
      if (bus.div_start) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 3'd3;
        ma       <= bus.div_a;
        mb       <= bus.div_b;
      end else if (mdl_busy) begin
        if (mdl_cnt == 3'd1) begin
          mdl_busy <= 1'b0;
          mdl_done <= 1'b1;
        end
        mdl_cnt <= mdl_cnt - 3'd1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.div_start) begin
      start_cnt  <= start_cnt + 1;
      start_gap  <= cyc - last_start;
      last_start <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_out(input int budget, output int waited);
    waited = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.out_valid === 1'b1) begin
        waited = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic drive_in(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
  endtask

  task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    drive_in(a, b, tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_val !== 8'h00) $display("FAIL rst_out_val: got %h expected 00", bus.out_val); else n_pass++;
    n_total++; if (bus.out_tag !== 4'h0) $display("FAIL rst_out_tag: got %h expected 0", bus.out_tag); else n_pass++;
    n_total++; if (bus.out_dbz !== 1'b0) $display("FAIL rst_out_dbz: got %b expected 0", bus.out_dbz); else n_pass++;
    n_total++; if (bus.out_ovf !== 1'b0) $display("FAIL rst_out_ovf: got %b expected 0", bus.out_ovf); else n_pass++;
    n_total++; if (bus.div_start !== 1'b0) $display("FAIL rst_div_start: got %b expected 0", bus.div_start); else n_pass++;
    n_total++; if (bus.div_a !== 8'h00) $display("FAIL rst_div_a: got %h expected 00", bus.div_a); else n_pass++;
    n_total++; if (bus.div_b !== 8'h00) $display("FAIL rst_div_b: got %h expected 00", bus.div_b); else n_pass++;
    n_total++; if (bus.level !== 3'd0) $display("FAIL rst_level: got %0d expected 0", bus.level); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    int s0;
    int w;
    s0 = start_cnt;
    drive_in(8'h30, 8'h20, 4'd3);
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++; if (bus.level !== 3'd1) $display("FAIL basic_level_n1: got %0d expected 1", bus.level); else n_pass++;
    n_total++; if (bus.div_start !== 1'b0) $display("FAIL basic_start_n1: got %b expected 0", bus.div_start); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.div_start !== 1'b1) $display("FAIL basic_start_n2: got %b expected 1", bus.div_start); else n_pass++;
    n_total++; if (bus.div_a !== 8'h30) $display("FAIL basic_div_a: got %h expected 30", bus.div_a); else n_pass++;
    n_total++; if (bus.div_b !== 8'h20) $display("FAIL basic_div_b: got %h expected 20", bus.div_b); else n_pass++;
    n_total++; if (bus.level !== 3'd0) $display("FAIL basic_level_n2: got %0d expected 0", bus.level); else n_pass++;
    wait_out(30, w);
    // start in cycle S, done in S+4, result visible in S+5
    n_total++; if (w !== 5) $display("FAIL basic_result_latency: got %0d expected 5", w); else n_pass++;
    n_total++; if (bus.out_val !== 8'h18) $display("FAIL basic_out_val: got %h expected 18", bus.out_val); else n_pass++;
    n_total++; if (bus.out_tag !== 4'd3) $display("FAIL basic_out_tag: got %0d expected 3", bus.out_tag); else n_pass++;
    n_total++; if ({bus.out_dbz, bus.out_ovf} !== 2'b00) $display("FAIL basic_flags: got %b expected 00", {bus.out_dbz, bus.out_ovf}); else n_pass++;
    n_total++; if (start_cnt - s0 !== 1) $display("FAIL basic_start_count: got %0d expected 1", start_cnt - s0); else n_pass++;
    drain();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drained: got %b expected 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_flags();
    int w;
    drive_in(8'h10, 8'h00, 4'd1);
    @(negedge clk);
    drive_in(8'h80, 8'h10, 4'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(30, w);
    n_total++; if (w < 0) $display("FAIL flags_timeout1: got none expected result"); else n_pass++;
    n_total++; if (bus.out_tag !== 4'd1) $display("FAIL flags_tag1: got %0d expected 1", bus.out_tag); else n_pass++;
    n_total++; if ({bus.out_dbz, bus.out_ovf} !== 2'b10) $display("FAIL flags_dbz: got %b expected 10", {bus.out_dbz, bus.out_ovf}); else n_pass++;
    n_total++; if (bus.out_val !== 8'h00) $display("FAIL flags_val1: got %h expected 00", bus.out_val); else n_pass++;
    drain();
    wait_out(30, w);
    n_total++; if (w < 0) $display("FAIL flags_timeout2: got none expected result"); else n_pass++;
    n_total++; if (bus.out_tag !== 4'd2) $display("FAIL flags_tag2: got %0d expected 2", bus.out_tag); else n_pass++;
    n_total++; if ({bus.out_dbz, bus.out_ovf} !== 2'b01) $display("FAIL flags_ovf: got %b expected 01", {bus.out_dbz, bus.out_ovf}); else n_pass++;
    n_total++; if (bus.out_val !== 8'h00) $display("FAIL flags_val2: got %h expected 00", bus.out_val); else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] tags [2];
    logic [7:0] vals [2];
    int idx;
    idx = 0;
    bus.out_ready = 1'b1;
    drive_in(8'h20, 8'h10, 4'd6);
    @(negedge clk);
    drive_in(8'h10, 8'h20, 4'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1 && idx < 2) begin
        tags[idx] = bus.out_tag;
        vals[idx] = bus.out_val;
        idx++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_total++; if (idx !== 2) $display("FAIL b2b_count: got %0d expected 2", idx); else n_pass++;
    n_total++; if (tags[0] !== 4'd6 || vals[0] !== 8'h20) $display("FAIL b2b_first: got tag %0d val %h expected tag 6 val 20", tags[0], vals[0]); else n_pass++;
    n_total++; if (tags[1] !== 4'd7 || vals[1] !== 8'h08) $display("FAIL b2b_second: got tag %0d val %h expected tag 7 val 08", tags[1], vals[1]); else n_pass++;
    n_total++; if (start_gap !== 7) $display("FAIL b2b_start_gap: got %0d expected 7", start_gap); else n_pass++;
  endtask

  task automatic test_fill();
    logic [7:0] exp_val [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    int acc;
    int idx;
    int s0;
    int bad;
    acc = 0;
    idx = 0;
    bad = 0;
    s0  = start_cnt;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive_in(8'((acc + 1) * 16), 8'h10, 4'(acc));
      if (bus.in_ready === 1'b1) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_total++; if (acc !== 5) $display("FAIL fill_accepted: got %0d expected 5", acc); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.level !== 3'd4) $display("FAIL fill_level: got %0d expected 4", bus.level); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL fill_slot_full: got %b expected 1", bus.out_valid); else n_pass++;
    n_total++; if (start_cnt - s0 !== 1) $display("FAIL fill_one_issue: got %0d expected 1", start_cnt - s0); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid === 1'b1) begin
        if (idx >= 5) bad++;
        else if (bus.out_tag !== 4'(idx) || bus.out_val !== exp_val[idx]) begin
          $display("FAIL fill_result%0d: got tag %0d val %h expected tag %0d val %h", idx, bus.out_tag, bus.out_val, idx, exp_val[idx]);
          bad++;
        end
        idx++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL fill_results_bad: got %0d expected 0", bad); else n_pass++;
    n_total++; if (idx !== 5) $display("FAIL fill_result_count: got %0d expected 5", idx); else n_pass++;
    n_total++; if (bus.level !== 3'd0) $display("FAIL fill_level_end: got %0d expected 0", bus.level); else n_pass++;
  endtask

  task automatic test_hold();
    int w;
    int s0;
    int bad;
    bad = 0;
    s0  = start_cnt;
    push_one(8'h30, 8'h10, 4'd9);
    wait_out(30, w);
    n_total++; if (w < 0) $display("FAIL hold_timeout: got none expected result"); else n_pass++;
    push_one(8'h10, 8'h10, 4'd10);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_val !== 8'h30 || bus.out_tag !== 4'd9 ||
          bus.out_dbz !== 1'b0 || bus.out_ovf !== 1'b0 || bus.div_start !== 1'b0) bad++;
      @(negedge clk);
    end
    n_total++; if (bad !== 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); else n_pass++;
    n_total++; if (start_cnt - s0 !== 1) $display("FAIL hold_no_issue: got %0d starts expected 1", start_cnt - s0); else n_pass++;
    n_total++; if (bus.level !== 3'd1) $display("FAIL hold_level: got %0d expected 1", bus.level); else n_pass++;
    drain();
    wait_out(30, w);
    n_total++; if (bus.out_tag !== 4'd10 || bus.out_val !== 8'h10) $display("FAIL hold_next: got tag %0d val %h expected tag 10 val 10", bus.out_tag, bus.out_val); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    seen = 0;
    drive_in(8'h10, 8'h10, 4'd11);
    @(negedge clk);
    drive_in(8'h20, 8'h10, 4'd12);
    @(negedge clk);
    drive_in(8'h30, 8'h10, 4'd13);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++; if (bus.level !== 3'd2) $display("FAIL rmid_level_before: got %0d expected 2", bus.level); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (bus.level !== 3'd0) $display("FAIL rmid_level: got %0d expected 0", bus.level); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.div_start !== 1'b0) $display("FAIL rmid_div_start: got %b expected 0", bus.div_start); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b0 || bus.div_start !== 1'b0) seen++;
      @(negedge clk);
    end
    n_total++; if (seen !== 0) $display("FAIL rmid_quiet: got %0d active cycles expected 0", seen); else n_pass++;
    push_one(8'h40, 8'h20, 4'd5);
    wait_out(30, w);
    n_total++; if (w < 0) $display("FAIL rmid_timeout: got none expected result"); else n_pass++;
    n_total++; if (bus.out_tag !== 4'd5 || bus.out_val !== 8'h20 || bus.out_dbz !== 1'b0)
      $display("FAIL rmid_after: got tag %0d val %h dbz %b expected tag 5 val 20 dbz 0", bus.out_tag, bus.out_val, bus.out_dbz); else n_pass++;
    drain();
  endtask

  task automatic test_stray();
    int w;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stray_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.level !== 3'd0) $display("FAIL stray_level: got %0d expected 0", bus.level); else n_pass++;
    n_total++; if (bus.div_start !== 1'b0) $display("FAIL stray_start: got %b expected 0", bus.div_start); else n_pass++;
    push_one(8'h20, 8'h20, 4'd4);
    wait_out(30, w);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd4 || bus.out_val !== 8'h10)
      $display("FAIL stray_held: got valid %b tag %0d val %h expected valid 1 tag 4 val 10", bus.out_valid, bus.out_tag, bus.out_val); else n_pass++;
    drain();
  endtask

  initial begin
    rst           = 1'b1;
    stray_done    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_fill();
    test_hold();
    test_reset_mid();
    test_stray();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_queue.md
# div_queue

Operand queue and result collector that sits directly around the fixed-point `div` divider. It accepts dividend/divisor pairs over a valid/ready stream and buffers them in a FIFO. It issues them one at a time to the divider's `start`/`a`/`b` pins, captures the divider's `val`/`dbz`/`ovf` on `done`, and presents tagged results on an output valid/ready stream in issue order.

## Interface
- `WIDTH`, 8: operand/result width in bits. Must equal the divider's WIDTH.
- `DEPTH`, 4: operand FIFO entries, power of two, ≥2.
- `TAGW`, 4: width of the user tag carried alongside each operation.

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset. Also drives the divider's `rst`.
- `in_valid` in 1: upstream operand pair valid.
- `in_ready` out 1: FIFO can accept; `!full`.
- `in_a` in WIDTH: signed dividend.
- `in_b` in WIDTH: signed divisor.
- `in_tag` in TAGW: user tag.
- `level` out $clog2(DEPTH+1): current FIFO occupancy.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_a` out WIDTH: dividend to the divider; registered.
- `div_b` out WIDTH: divisor to the divider; registered.
- `div_done` in 1: divider completion pulse.
- `div_dbz` in 1: divider divide-by-zero flag; valid with `div_done`.
- `div_ovf` in 1: divider overflow flag; valid with `div_done`.
- `div_val` in WIDTH: divider quotient; valid with `div_done`.
- `out_valid` out 1: result slot full.
- `out_ready` in 1: downstream accepts.
- `out_val` out WIDTH: quotient; 0 when dbz or ovf.
- `out_tag` out TAGW: tag of the operation.
- `out_dbz` out 1: divide-by-zero flag for the operation.
- `out_ovf` out 1: overflow flag for the operation.

## Operation
- **Push:** on `in_valid && in_ready`, {in_a, in_b, in_tag} is written at the write pointer. No bypass: when full, `in_ready`=0 even if a pop occurs in the same cycle.
- **Pointers:** read and write pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and lower bits are equal.
  - empty = pointers equal.
  - Simultaneous push and pop leaves `level` unchanged.
- **FSM states:** IDLE, WAIT.
  - IDLE: if FIFO is non-empty and `out_valid`=0, pop the head. `div_a`/`div_b` and an internal tag register load next cycle, `div_start`<=1, and the FSM goes to WAIT.
  - WAIT: `div_start`<=0 after its single cycle. On `div_done`:
    - `out_val`<= (div_dbz|div_ovf) ? 0 : div_val
    - `out_dbz`<=div_dbz, `out_ovf`<=div_ovf, `out_tag`<=tag register
    - `out_valid`<=1, FSM returns to IDLE
- **Outstanding operations:** only one operation is outstanding. Issue is gated on an empty result slot, so a `done` pulse can never be lost.
- **Result hold:** `div_a`/`div_b` are held stable from the `div_start` cycle until the next issue.
- **Output handshake:** `out_valid` clears on `out_valid && out_ready`. Output fields hold while `out_valid`=1 and `out_ready`=0.
- **Stray done:** `div_done` while the FSM is in IDLE is ignored.
- **Ordering:** results leave in push order. Tags are passed through unmodified.

## Timing
- **Reset values:** all outputs 0, except `in_ready`=1. Specifically:
  - `out_valid`=0, `out_val`=0, `out_tag`=0, `out_dbz`=0, `out_ovf`=0
  - `div_start`=0, `div_a`=0, `div_b`=0
  - `level`=0, FSM=IDLE, pointers=0
- **Push to start:**
  - Push accepted in cycle N.
  - Entry visible in cycle N+1; FSM pops in N+1.
  - `div_start` is high in cycle N+2 only (FIFO and slot empty).
- **Done to result:** `div_done` in cycle D gives `out_valid`=1 in D+1. The earliest next `div_start` is D+3, given the slot is drained in D+1.
- **Issue gating:** issue requires `out_valid`=0 in the IDLE evaluation cycle. A slot freed by a drain in cycle X permits a pop in X+1.
- **Reset mid-operation:** `rst` asserted in any state discards the FIFO contents, the in-flight operation and the result slot within one cycle. The divider is reset on the same edge.
- **Throughput:** one result per (divider latency + 3) cycles with `out_ready` held high.

## Test plan
- **Basic divide:** WIDTH=8, FBITS=4 divider. Push a=0x30, b=0x20, tag=3 → `out_valid` with `out_val`=0x18, `out_tag`=3, `out_dbz`=0, `out_ovf`=0. `div_start` high exactly once, 2 cycles after the push.
- **Error flags:** push b=0 (tag 1), then a=0x80, b=0x10 (tag 2) → results in order:
  - tag 1: `out_dbz`=1, `out_val`=0
  - tag 2: `out_ovf`=1, `out_val`=0
- **Backpressure and fill:** DEPTH=4, `out_ready`=0, push back-to-back → exactly 5 pushes accepted, then `in_ready`=0 and `level`=4. Raise `out_ready` → all 5 results emerge in tag order 0..4 with no loss or duplication.
- **Result hold:** hold `out_ready`=0 for 20 cycles after a result → `out_*` fields stable throughout and no new `div_start` pulse.
- **Reset mid-operation:** assert `rst` for 1 cycle during WAIT with 2 entries queued → next cycle `level`=0, `out_valid`=0, `div_start`=0. No result appears afterwards. A new push completes normally.
- **Stray done:** force `div_done`=1 while the FSM is in IDLE → no change on `out_valid` or `level`.
